rle_encoder: RTL and testbench
==============================

// Module: rle_encoder
// PURPOSE
// Run-length encoder between the sampler and sample_fifo. Consumes sampler dataOut/validOut.
// Writes value and count words to the FIFO data/write-strobe port, so repeated samples use less depth.
// With rle_en low it is a 1-cycle registered pass-through; the controller drives rle_en/flush/clear.
// PARAMETERS
// SAMPLE_WIDTH  8  width of sample and of output word; RLE uses MSB as flag, [W-2:0] as payload
// PORTS
// clock       in   1    system clock
// reset_n     in   1    asynchronous active-low reset
// rle_en      in   1    1=encode, 0=pass-through; sampled only while state==IDLE
// clear       in   1    synchronous: drop run/pending, return to IDLE, no output
// flush       in   1    1-cycle pulse: emit outstanding words, then pulse flush_done
// data_in     in   W    sample from sampler
// valid_in    in   1    sample strobe, may be high every cycle
// data_out    out  W    word to FIFO
// valid_out   out  1    FIFO write strobe, 1 cycle per word
// flush_done  out  1    1-cycle pulse when flush has fully drained
// busy        out  1    1 while run count>0 or pending word held
// BEHAVIOUR
// - Reset/clear: data_out=0, valid_out=0, flush_done=0, busy=0, last=0, cnt=0, pend_v=0, state=IDLE.
// - Word format (encode): MSB=0 -> value word {1'b0, sample[W-2:0]}; MSB=1 -> count word {1'b1, cnt}.
//   Count word = number of additional repeats of the preceding value, 1..2^(W-1)-1 (127 at W=8).
// - Pass-through (rle_en=0): data_out<=data_in, valid_out<=valid_in, latency 1, full width, no flags.
// - FSM: IDLE -> RUN on first valid_in; RUN -> FLUSH on flush; FLUSH -> IDLE after drain.
//   Any state -> IDLE on clear.
// - IDLE + valid_in: emit value word next cycle; last<=data_in[W-2:0]; cnt<=0.
// - RUN + valid_in, payload==last: cnt<=cnt+1, no word.
//   If cnt+1 reaches max, emit count word max and set cnt<=0; the run continues.
// - RUN + valid_in, payload!=last:
//   - cnt==0: emit value word.
//   - cnt>0: emit count word cnt this cycle; value word goes to pend register (pend_v=1); cnt<=0.
// - Pending drain: pend_v=1 always outputs pend next cycle (priority over new words).
//   A same-cycle new value word replaces pend; a new count word cannot occur (cnt==0 after change).
// - Output rate invariant: <=1 word per cycle; pend depth 1 is sufficient; no input is ever dropped.
// - Compare uses payload bits [W-2:0] only in encode mode; bit W-1 of input ignored.
// - FLUSH: valid_in ignored (controller stops sampling first).
//   Drain pend, then count word if cnt>0; flush_done pulses the cycle after the last word (or next cycle if nothing left).
// - flush in IDLE: flush_done next cycle, no words.
// - clear wins over flush/valid_in in the same cycle.
// - reset_n asserted mid-run discards all state immediately.
// - rle_en change while RUN/FLUSH is ignored until IDLE.
// STRUCTURE
// - acsp_pkg (shared package), holding:
//   - typedef enum logic [1:0] {RLE_IDLE, RLE_RUN, RLE_FLUSH} rle_state_t
//   - localparam RLE_FLAG_BIT = SAMPLE_WIDTH-1
//   - function rle_cnt_max(w) = 2**(w-1)-1
// - Single module, no sub-modules; output register + 1-entry pend register inline.
// TESTING
// - Pass-through: rle_en=0, valid_in each cycle with 8'h00,8'hFF,8'h81 -> same bytes one cycle later.
// - Basic run: rle_en=1, inputs 05,05,05,09 back-to-back, then flush.
//   Expected: valid words 05, 82 (count 2), 09; then flush_done.
// - Saturation: 130 consecutive 8'h11.
//   Expected: 11, then FF (count 127) after input 128; flush emits 82 (count 2); flush_done.
// - Worst rate: 01,01,02,02,03,03 every cycle.
//   Expected: 01,81,02,81,03 with valid_out never dropping a word; busy; then flush gives 81, flush_done.
// - Change after change: 01,01,02,03 back-to-back.
//   Expected: 01,81,02,03 in consecutive cycles (pend replaced correctly).
// - Clear/reset mid-run: 07,07,07 then clear (or reset_n=0) -> no count word, outputs 0, busy=0, state IDLE.

Source files
------------

// File: rtl/acsp_pkg.sv
// Shared types and constants for the acquisition sample path.
// The run-length encoder takes its state encoding and count limit from here.
package acsp_pkg;

  localparam int ACSP_SAMPLE_WIDTH = 8;
  localparam int RLE_FLAG_BIT      = ACSP_SAMPLE_WIDTH - 1;

  typedef enum logic [1:0] {
    RLE_IDLE,
    RLE_RUN,
    RLE_FLUSH
  } rle_state_t;

  // Largest repeat count a count word can carry for a given word width.
  function automatic int rle_cnt_max(input int w);
    return (2 ** (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/rle_encoder.sv
// Run-length encoder between the sampler and sample_fifo, or a 1-cycle registered pass-through.
// Each encoded word has an MSB flag: 0 marks a value word, 1 marks a count word of extra repeats.
module rle_encoder
  import acsp_pkg::*;
#(
  parameter int SAMPLE_WIDTH = ACSP_SAMPLE_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    rle_en,
  input  logic                    clear,
  input  logic                    flush,
  input  logic [SAMPLE_WIDTH-1:0] data_in,
  input  logic                    valid_in,
  output logic [SAMPLE_WIDTH-1:0] data_out,
  output logic                    valid_out,
  output logic                    flush_done,
  output logic                    busy
);

  localparam int W        = SAMPLE_WIDTH;
  localparam int FLAG_BIT = W - 1;
  localparam logic [W-2:0] CNT_MAX = (W-1)'(rle_cnt_max(W));

  function automatic logic [W-1:0] value_word(input logic [W-2:0] p);
    return {1'b0, p};
  endfunction

  function automatic logic [W-1:0] count_word(input logic [W-2:0] n);
    return {1'b1, n};
  endfunction

  rle_state_t     state, state_nx;
  logic [W-2:0]   last, last_nx;
  logic [W-2:0]   cnt, cnt_nx;
  logic [W-1:0]   pend, pend_nx;
  logic           pend_v, pend_v_nx;
  logic [W-1:0]   dout_nx;
  logic           vout_nx;
  logic           fdone_nx;

  logic [W-2:0]   payload;
  logic [W-2:0]   cnt_inc;
  logic [W-1:0]   word_p0;
  logic           vld_p0;
  logic           defer_p0;
  logic           drain;
  logic           pass;

  assign payload = data_in[FLAG_BIT-1:0];
  assign cnt_inc = cnt + (W-1)'(1);
  assign busy    = pend_v | (cnt != '0);

  // Stage 0: classify the incoming sample and pick this cycle's word
  always_comb begin
    state_nx  = state;
    last_nx   = last;
    cnt_nx    = cnt;
    pend_nx   = pend;
    pend_v_nx = pend_v;
    dout_nx   = data_out;
    vout_nx   = 1'b0;
    fdone_nx  = 1'b0;
    word_p0   = '0;
    vld_p0    = 1'b0;
    defer_p0  = 1'b0;
    drain     = 1'b0;
    pass      = 1'b0;

    unique case (state)
      RLE_IDLE: begin
        if (!rle_en) begin
          pass     = 1'b1;
          dout_nx  = data_in;
          vout_nx  = valid_in;
          fdone_nx = flush;
        end else if (flush) begin
          fdone_nx = 1'b1;
        end else if (valid_in) begin
          vld_p0   = 1'b1;
          word_p0  = value_word(payload);
          last_nx  = payload;
          cnt_nx   = '0;
          state_nx = RLE_RUN;
        end
      end
      RLE_RUN: begin
        if (flush) begin
          drain    = 1'b1;
          state_nx = RLE_FLUSH;
        end else if (valid_in) begin
          if (payload == last) begin
            if (cnt_inc == CNT_MAX) begin
              vld_p0  = 1'b1;
              word_p0 = count_word(CNT_MAX);
              cnt_nx  = '0;
            end else begin
              cnt_nx = cnt_inc;
            end
          end else begin
            last_nx = payload;
            cnt_nx  = '0;
            vld_p0  = 1'b1;
            if (cnt == '0) begin
              word_p0 = value_word(payload);
            end else begin
              // The closing count word goes out now; the new value waits one cycle.
              word_p0  = count_word(cnt);
              defer_p0 = 1'b1;
            end
          end
        end
      end
      RLE_FLUSH: drain = 1'b1;
      default:   state_nx = RLE_IDLE;
    endcase

    if (drain && !pend_v) begin
      if (cnt != '0) begin
        vld_p0  = 1'b1;
        word_p0 = count_word(cnt);
        cnt_nx  = '0;
      end else begin
        fdone_nx = 1'b1;
        state_nx = RLE_IDLE;
      end
    end

    // A held word always goes first; only a value word can arrive alongside it.
    if (!pass) begin
      if (pend_v) begin
        dout_nx   = pend;
        vout_nx   = 1'b1;
        pend_v_nx = vld_p0;
        if (vld_p0) pend_nx = word_p0;
      end else if (vld_p0) begin
        dout_nx   = word_p0;
        vout_nx   = 1'b1;
        pend_v_nx = defer_p0;
        if (defer_p0) pend_nx = value_word(payload);
      end
    end

    if (clear) begin
      state_nx  = RLE_IDLE;
      last_nx   = '0;
      cnt_nx    = '0;
      pend_nx   = '0;
      pend_v_nx = 1'b0;
      dout_nx   = '0;
      vout_nx   = 1'b0;
      fdone_nx  = 1'b0;
    end
  end

  // Stage 1: output register, run tracking and one-entry pend register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= RLE_IDLE;
      last       <= '0;
      cnt        <= '0;
      pend       <= '0;
      pend_v     <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_nx;
      last       <= last_nx;
      cnt        <= cnt_nx;
      pend       <= pend_nx;
      pend_v     <= pend_v_nx;
      data_out   <= dout_nx;
      valid_out  <= vout_nx;
      flush_done <= fdone_nx;
    end
  end

endmodule

// File: tb/tb_rle_encoder.sv
// Self-checking bench for rle_encoder: directed spec scenarios plus randomized runs
// compared against a run-length reference model built from whole runs of equal payloads.
module tb_rle_encoder;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         rle_en;
  logic         clear;
  logic         flush;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic [W-1:0] data_out;
  logic         valid_out;
  logic         flush_done;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [W-1:0] got_q[$];
  int           got_t[$];
  int           fd_cnt = 0;
  int           fd_t   = 0;

  logic [W-1:0] stim_q[$];
  logic [W-1:0] exp_q[$];

  rle_encoder #(.SAMPLE_WIDTH(W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rle_en     (rle_en),
    .clear      (clear),
    .flush      (flush),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .flush_done (flush_done),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Word and flush_done log, stamped with the cycle in which they are visible.
  always @(negedge clock) begin
    if (valid_out === 1'b1) begin
      got_q.push_back(data_out);
      got_t.push_back(cyc);
    end
    if (flush_done === 1'b1) begin
      fd_cnt = fd_cnt + 1;
      fd_t   = cyc;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Reference: every maximal run of equal 7-bit payloads of length L becomes a value
  // word, then one 0xFF per full 127 repeats, then the leftover repeat count if nonzero.
  function automatic void build_expected();
    int i;
    int len;
    int rep;
    logic [6:0] p;
    exp_q.delete();
    i = 0;
    while (i < stim_q.size()) begin
      p   = stim_q[i][6:0];
      len = 1;
      while (i + len < stim_q.size() && stim_q[i+len][6:0] == p) len++;
      exp_q.push_back({1'b0, p});
      rep = len - 1;
      while (rep >= 127) begin
        exp_q.push_back(8'hFF);
        rep -= 127;
      end
      if (rep > 0) exp_q.push_back({1'b1, 7'(rep)});
      i += len;
    end
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d);
    valid_in = v;
    data_in  = d;
    @(posedge clock);
    #1;
  endtask

  // Plays stim_q in encode mode, flushes, and checks the word stream and flush handshake.
  task automatic test_stream(input string name, input int gap_pct, input bit wiggle,
                             output int base, output int c0, output logic bsy);
    int fdb, f, k, last_t, exp_fd, nfd;
    base   = got_q.size();
    fdb    = fd_cnt;
    rle_en = 1'b1;
    c0     = cyc;
    foreach (stim_q[i]) begin
      while ($urandom_range(99) < gap_pct) drive(1'b0, 8'($urandom));
      drive(1'b1, stim_q[i]);
      if (wiggle) rle_en = 1'($urandom);
    end
    bsy      = busy;
    valid_in = 1'b0;
    flush    = 1'b1;
    f        = cyc;
    @(posedge clock);
    #1;
    flush = 1'b0;
    k = 0;
    while (fd_cnt == fdb && k < 600) begin
      @(posedge clock);
      #1;
      k++;
    end
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    rle_en = 1'b1;
    nfd    = fd_cnt - fdb;

    build_expected();
    n_cmp++;
    if (got_q.size() - base !== exp_q.size()) begin
      n_bad++;
      $display("FAIL %s_word_count: got %0d words, need %0d", name, got_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[base+i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s_word%0d: got %02h, need %02h", name, i, got_q[base+i], exp_q[i]);
      end
    end
    last_t = (got_q.size() > base) ? got_t[got_t.size()-1] : f;
    exp_fd = ((last_t > f) ? last_t : f) + 1;
    n_cmp++;
    if (nfd !== 1 || fd_t !== exp_fd) begin
      n_bad++;
      $display("FAIL %s_flush_done: got %0d pulses at cycle %0d, need 1 pulse at cycle %0d",
               name, nfd, fd_t, exp_fd);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_busy_after_flush: got %b, need 0", name, busy);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    rle_en   = 1'b1;
    clear    = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data_out: got %02h, need 00", data_out); end
    n_cmp++;
    if (valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid_out: got %b, need 0", valid_out); end
    n_cmp++;
    if (flush_done !== 1'b0) begin n_bad++; $display("FAIL reset_flush_done: got %b, need 0", flush_done); end
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b, need 0", busy); end
    reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_passthrough();
    logic [W-1:0] pt[3];
    int base, c0;
    pt[0] = 8'h00;
    pt[1] = 8'hFF;
    pt[2] = 8'h81;
    rle_en = 1'b0;
    base   = got_q.size();
    c0     = cyc;
    for (int i = 0; i < 3; i++) drive(1'b1, pt[i]);
    drive(1'b0, 8'h3C);
    drive(1'b0, 8'h3C);
    n_cmp++;
    if (got_q.size() - base !== 3) begin
      n_bad++;
      $display("FAIL passthrough_count: got %0d words, need 3", got_q.size() - base);
    end
    for (int i = 0; i < 3 && base + i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[base+i] !== pt[i] || got_t[base+i] !== c0 + i + 1) begin
        n_bad++;
        $display("FAIL passthrough_word%0d: got %02h at cycle %0d, need %02h at cycle %0d",
                 i, got_q[base+i], got_t[base+i], pt[i], c0 + i + 1);
      end
    end
    rle_en = 1'b1;
  endtask

  task automatic test_basic_run();
    int base, c0;
    logic bsy;
    stim_q = '{8'h05, 8'h05, 8'h05, 8'h09};
    test_stream("basic", 0, 1'b0, base, c0, bsy);
  endtask

  task automatic test_saturation();
    int base, c0;
    logic bsy;
    stim_q.delete();
    repeat (130) stim_q.push_back(8'h11);
    test_stream("saturation", 0, 1'b0, base, c0, bsy);
    n_cmp++;
    if (got_t.size() < base + 2 || got_t[base+1] !== c0 + 128) begin
      n_bad++;
      $display("FAIL saturation_ff_timing: got cycle %0d, need cycle %0d",
               (got_t.size() >= base + 2) ? got_t[base+1] - c0 : -1, 128);
    end
    n_cmp++;
    if (bsy !== 1'b1) begin n_bad++; $display("FAIL saturation_busy: got %b, need 1", bsy); end
  endtask

  task automatic test_worst_rate();
    int base, c0;
    logic bsy;
    stim_q = '{8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03};
    test_stream("worst_rate", 0, 1'b0, base, c0, bsy);
    n_cmp++;
    if (bsy !== 1'b1) begin n_bad++; $display("FAIL worst_rate_busy: got %b, need 1", bsy); end
  endtask

  task automatic test_change_after_change();
    int base, c0;
    logic bsy;
    stim_q = '{8'h01, 8'h01, 8'h02, 8'h03};
    test_stream("change_change", 0, 1'b0, base, c0, bsy);
    n_cmp++;
    if (got_t.size() < base + 4 ||
        got_t[base+2] - got_t[base+1] !== 1 || got_t[base+3] - got_t[base+2] !== 1) begin
      n_bad++;
      $display("FAIL change_change_consecutive: got %0d words, last three not in consecutive cycles",
               got_t.size() - base);
    end
  endtask

  task automatic test_flush_idle();
    int base, fdb, f;
    rle_en = 1'b1;
    base   = got_q.size();
    fdb    = fd_cnt;
    f      = cyc;
    flush  = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    n_cmp++;
    if (fd_cnt - fdb !== 1 || fd_t !== f + 1) begin
      n_bad++;
      $display("FAIL flush_idle_done: got %0d pulses at cycle %0d, need 1 at cycle %0d",
               fd_cnt - fdb, fd_t, f + 1);
    end
    n_cmp++;
    if (got_q.size() !== base) begin
      n_bad++;
      $display("FAIL flush_idle_words: got %0d words, need 0", got_q.size() - base);
    end
  endtask

  task automatic test_clear();
    int base, fdb, c0;
    logic bsy;
    rle_en = 1'b1;
    base   = got_q.size();
    fdb    = fd_cnt;
    repeat (3) drive(1'b1, 8'h07);
    clear = 1'b1;
    flush = 1'b1;
    drive(1'b1, 8'h07);
    clear    = 1'b0;
    flush    = 1'b0;
    valid_in = 1'b0;
    n_cmp++;
    if (data_out !== 8'h00 || valid_out !== 1'b0 || busy !== 1'b0 || flush_done !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_outputs: got data %02h valid %b busy %b done %b, need 00 0 0 0",
               data_out, valid_out, busy, flush_done);
    end
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    n_cmp++;
    if (got_q.size() - base !== 1 || got_q[base] !== 8'h07 || fd_cnt !== fdb) begin
      n_bad++;
      $display("FAIL clear_words: got %0d words and %0d flush_done, need only word 07",
               got_q.size() - base, fd_cnt - fdb);
    end
    stim_q = '{8'h09, 8'h09};
    test_stream("after_clear", 0, 1'b0, base, c0, bsy);
  endtask

  task automatic test_reset_mid_run();
    int base, c0;
    logic bsy;
    rle_en = 1'b1;
    base   = got_q.size();
    repeat (3) drive(1'b1, 8'h07);
    valid_in = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (data_out !== 8'h00 || valid_out !== 1'b0 || busy !== 1'b0 || flush_done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_run_outputs: got data %02h valid %b busy %b done %b, need 00 0 0 0",
               data_out, valid_out, busy, flush_done);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    n_cmp++;
    if (got_q.size() - base !== 1) begin
      n_bad++;
      $display("FAIL reset_mid_run_words: got %0d words, need 1", got_q.size() - base);
    end
    stim_q = '{8'h0A, 8'h0A};
    test_stream("after_reset", 0, 1'b0, base, c0, bsy);
  endtask

  task automatic test_random();
    int base, c0, nruns, len;
    logic bsy;
    logic [6:0] p;
    for (int it = 0; it < 4; it++) begin
      stim_q.delete();
      nruns = $urandom_range(10, 4);
      for (int r = 0; r < nruns; r++) begin
        p   = 7'($urandom_range(3, 0));
        len = ($urandom_range(7, 0) == 0) ? $urandom_range(270, 120) : $urandom_range(5, 1);
        repeat (len) stim_q.push_back({1'($urandom), p});
      end
      test_stream($sformatf("random%0d", it), 25, 1'b1, base, c0, bsy);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_basic_run();
    test_saturation();
    test_worst_rate();
    test_change_after_change();
    test_flush_idle();
    test_clear();
    test_reset_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
